// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the integer register file / scoreboard slice.
//   XLEN     : register data width
//   NREGS    : architectural register count (x0 hardwired to zero)
//   AW       : register index width, log2(NREGS)
//   NSRC     : source operand read ports per issued instruction
//   REG_ZERO : index of the hardwired zero register
package regfile_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NSRC  = 2;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decoder/writeback <-> register file bundle.
//   master : decoder + execute side (drives issue_* and wb_*)
//   slave  : register file (drives rdata1/2, stall, busy_count, wb_err)
interface regfile_scoreboard_if;
  import regfile_pkg::*;
  logic            issue_valid;
  logic [AW-1:0]   issue_rs1;
  logic [AW-1:0]   issue_rs2;
  logic [AW-1:0]   issue_rd;
  logic            issue_wr;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            stall;
  logic [AW:0]     busy_count;
  logic            wb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
    output wb_valid, wb_rd, wb_data,
    input  rdata1, rdata2, stall, busy_count, wb_err
  );
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
    input  wb_valid, wb_rd, wb_data,
    output rdata1, rdata2, stall, busy_count, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard_hazard_check.sv
// Combinational hazard detection and bypass select.
//   rs          : source indices, one lane per read port
//   issue_*     : decoder request qualifiers
//   wb_valid/rd : same-cycle writeback (resolves hazards through the bypass)
//   busy        : scoreboard state
//   bypass      : per-port select of wb_data over the stored value
//   stall       : hold the current instruction
module hazard_check
  import regfile_pkg::*;
(
  input  logic [NSRC-1:0][AW-1:0] rs,
  input  logic                    issue_valid,
  input  logic                    issue_wr,
  input  logic [AW-1:0]           issue_rd,
  input  logic                    wb_valid,
  input  logic [AW-1:0]           wb_rd,
  input  logic [NREGS-1:0]        busy,
  output logic [NSRC-1:0]         bypass,
  output logic                    stall
);
  logic [NSRC-1:0] src_haz;
  logic            waw;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign bypass[g]  = wb_valid && (wb_rd == rs[g]) && (wb_rd != REG_ZERO);
    // busy[0] is always clear, so x0 never raises a hazard here
    assign src_haz[g] = busy[rs[g]] && !(wb_valid && (wb_rd == rs[g]));
  end

  assign waw   = issue_wr && (issue_rd != REG_ZERO) && busy[issue_rd] &&
                 !(wb_valid && (wb_rd == issue_rd));
  assign stall = issue_valid && ((|src_haz) || waw);
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of regfile_scoreboard_if
//                issue_* in, wb_* in, rdata1/2 + stall out (combinational),
//                busy_count (popcount of busy) and sticky wb_err out (registered)
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busy_nxt;
  logic [NREGS-1:0]           set_vec;
  logic [NREGS-1:0]           clr_vec;
  logic [AW:0]                busy_count;
  logic                       wb_err;
  logic [NSRC-1:0][AW-1:0]    rs;
  logic [NSRC-1:0]            bypass;
  logic [NSRC-1:0][XLEN-1:0]  rdata;
  logic                       stall;
  logic                       accept;
  logic                       inc;
  logic                       dec;

  assign rs = {bus.issue_rs2, bus.issue_rs1};

  hazard_check u_hz (
    .rs          (rs),
    .issue_valid (bus.issue_valid),
    .issue_wr    (bus.issue_wr),
    .issue_rd    (bus.issue_rd),
    .wb_valid    (bus.wb_valid),
    .wb_rd       (bus.wb_rd),
    .busy        (busy),
    .bypass      (bypass),
    .stall       (stall)
  );

  always_comb begin
    for (int p = 0; p < NSRC; p++) begin
      if (rs[p] == REG_ZERO) rdata[p] = '0;
      else if (bypass[p])    rdata[p] = bus.wb_data;
      else                   rdata[p] = regs[rs[p]];
    end
  end

  assign accept = bus.issue_valid && !stall && !reset;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && bus.issue_wr && (bus.issue_rd != REG_ZERO)) set_vec[bus.issue_rd] = 1'b1;
    if (bus.wb_valid && (bus.wb_rd != REG_ZERO))              clr_vec[bus.wb_rd]    = 1'b1;
  end

  // Set wins: a clear and a set on the same register retire the older write
  // while the newly issued one stays outstanding.
  assign busy_nxt = (busy & ~clr_vec) | set_vec;
  // At most one set and one clear per cycle, so the count moves by -1..+1.
  assign inc = |(set_vec & ~busy);
  assign dec = |(clr_vec & busy & ~set_vec);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs       <= '0;
      busy       <= '0;
      busy_count <= '0;
      wb_err     <= 1'b0;
    end else begin
      if (bus.wb_valid && (bus.wb_rd != REG_ZERO)) regs[bus.wb_rd] <= bus.wb_data;
      busy       <= {busy_nxt[NREGS-1:1], 1'b0};
      busy_count <= busy_count + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
      if (bus.wb_valid && ((bus.wb_rd == REG_ZERO) || !busy[bus.wb_rd])) wb_err <= 1'b1;
    end
  end

  assign bus.rdata1     = rdata[0];
  assign bus.rdata2     = rdata[1];
  assign bus.stall      = stall;
  assign bus.busy_count = busy_count;
  assign bus.wb_err     = wb_err;
endmodule
